// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer plus per-bit stability counter.
// Emits clean levels for the button PIO and one-cycle press/release strobes.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] button_level,
  output logic [WIDTH-1:0] button_pressed,
  output logic [WIDTH-1:0] button_released
);

  localparam logic             IDLE_BIT    = (ACTIVE_LOW != 0);
  localparam logic             PRESSED_BIT = (ACTIVE_LOW == 0);
  localparam logic [WIDTH-1:0] IDLE        = {WIDTH{IDLE_BIT}};
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The counter must be able to reach DEBOUNCE_CYCLES-1 without wrapping.
  if (DEBOUNCE_CYCLES < 1 ||
      (longint'(DEBOUNCE_CYCLES) - 64'sd1) > ((64'sd1 <<< CNT_W) - 64'sd1)) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= IDLE;
      sync2_reg <= IDLE;
    end else begin
      sync1_reg <= button_raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             level_reg, level_next;
      logic             pressed_reg, pressed_next;
      logic             released_reg, released_next;

      always_comb begin
        cnt_next      = cnt_reg;
        level_next    = level_reg;
        pressed_next  = 1'b0;
        released_next = 1'b0;
        if (sync2_reg[gi] == level_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST) begin
          // Input has differed from the level long enough: accept it.
          level_next = sync2_reg[gi];
          cnt_next   = '0;
          if (sync2_reg[gi] == PRESSED_BIT) begin
            pressed_next = 1'b1;
          end else begin
            released_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg      <= '0;
          level_reg    <= IDLE_BIT;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
        end else begin
          cnt_reg      <= cnt_next;
          level_reg    <= level_next;
          pressed_reg  <= pressed_next;
          released_reg <= released_next;
        end
      end

      assign button_level[gi]    = level_reg;
      assign button_pressed[gi]  = pressed_reg;
      assign button_released[gi] = released_reg;
    end
  endgenerate

endmodule
